// File: rtl/modport_stepgen_if.sv
// Command/readback and driver-pin bundle for modport_stepgen.
// master = the step generator itself; slave = register block plus driver pins.
interface modport_stepgen_if;
  logic               pause;
  logic               enable_driver;
  logic               dc_enable;
  logic signed [16:0] pulsewidth;
  logic signed [31:0] position;
  logic               dcmiss;
  logic               step;
  logic               dir;
  logic               drv_enn;
  logic               dce;
  logic               dci;
  logic               dco;

  modport master (
    input  pause, enable_driver, dc_enable, pulsewidth, dco,
    output position, dcmiss, step, dir, drv_enn, dce, dci
  );

  modport slave (
    output pause, enable_driver, dc_enable, pulsewidth, dco,
    input  position, dcmiss, step, dir, drv_enn, dce, dci
  );
endinterface

// File: rtl/modport_stepgen.sv
// STEP/DIR pulse generator for a TMC5130A-class driver with signed position tracking.
// Optional dcStep pins (DCEN/DCIN/DCO miss detection) are built when DCSTEP_EN is defined.
module modport_stepgen #(
  parameter int CLK_FREQ  = 100000000,
  parameter int STEP_HIGH = 10,
  parameter int SEQ_LEN   = 22
) (
  input logic               clk,
  input logic               resetn,
  modport_stepgen_if.master bus
);

  localparam int SEQ_W = $clog2(SEQ_LEN + 1);
  localparam logic [SEQ_W-1:0] SEQ_START = SEQ_W'(SEQ_LEN);
  localparam logic [SEQ_W-1:0] S_RISE    = SEQ_W'(SEQ_LEN - 2);
  localparam logic [SEQ_W-1:0] S_FALL    = SEQ_W'(SEQ_LEN - 2 - STEP_HIGH);

  if (CLK_FREQ <= 0) begin : g_bad_clk_freq
    $error("CLK_FREQ must be positive");
  end
  if (STEP_HIGH < 1 || STEP_HIGH > 15) begin : g_bad_step_high
    $error("STEP_HIGH must be in 1..15");
  end
  if (SEQ_LEN < STEP_HIGH + 2) begin : g_bad_seq_len
    $error("SEQ_LEN must be at least STEP_HIGH+2");
  end

  logic [31:0]        r_cnt;
  logic [SEQ_W-1:0]   r_seq;
  logic               r_step;
  logic               r_dir;
  logic signed [31:0] r_pos;
  logic               r_dcmiss;

  logic [16:0]        w_mag;
  logic [31:0]        w_cnt_inc;
  logic [SEQ_W-1:0]   w_seq_dec;
  logic               w_trigger;
  logic               w_dce;
  logic               w_miss;

  // -65536 negates to 17'h10000, which is the correct unsigned magnitude.
  assign w_mag     = bus.pulsewidth[16] ? (17'd0 - bus.pulsewidth) : bus.pulsewidth;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 32'd1;
  assign w_seq_dec = r_seq - SEQ_W'(1);
  assign w_trigger = (w_mag != 17'd0) && (w_cnt_inc >= {15'd0, w_mag}) &&
                     (r_seq == '0) && !bus.pause;

`ifdef DCSTEP_EN
  assign w_dce  = resetn & bus.enable_driver & bus.dc_enable;
  assign w_miss = w_dce & ~bus.dco;
`else
  logic w_unused_dc;
  assign w_unused_dc = bus.dc_enable ^ bus.dco;
  assign w_dce       = 1'b0;
  assign w_miss      = 1'b0;
`endif

  assign bus.drv_enn  = !(resetn && bus.enable_driver);
  assign bus.dce      = w_dce;
  assign bus.dci      = r_step & w_dce;
  assign bus.step     = r_step;
  assign bus.dir      = r_dir;
  assign bus.position = r_pos;
  assign bus.dcmiss   = r_dcmiss;

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_seq    <= '0;
      r_step   <= 1'b0;
      r_dir    <= 1'b0;
      r_pos    <= '0;
      r_dcmiss <= 1'b0;
    end else if (bus.enable_driver) begin
      r_dcmiss <= 1'b0;
      if (w_trigger) begin
        r_cnt <= '0;
        r_dir <= bus.pulsewidth[16];
        r_seq <= SEQ_START;
      end else begin
        r_cnt <= w_cnt_inc;
        // A running sequence always completes, whatever pause or pulsewidth do.
        if (r_seq != '0) begin
          r_seq <= w_seq_dec;
          if (w_seq_dec == S_RISE) begin
            r_step <= 1'b1;
            r_pos  <= r_dir ? r_pos - 32'sd1 : r_pos + 32'sd1;
          end
          if (w_seq_dec == S_FALL)
            r_step <= 1'b0;
          if (w_seq_dec == '0 && w_miss)
            r_dcmiss <= 1'b1;
        end
      end
    end else begin
      r_dcmiss <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modport_stepgen.sv
// Directed bench for modport_stepgen: timeline model compared every cycle plus literal pins.
module tb_modport_stepgen;
  localparam int STEP_HIGH = 10;
  localparam int SEQ_LEN   = 22;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  modport_stepgen_if bus();

  modport_stepgen #(
    .CLK_FREQ (100000000),
    .STEP_HIGH(STEP_HIGH),
    .SEQ_LEN  (SEQ_LEN)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time since the last trigger (age) and since the last period restart.
  int     m_pos    = 0;
  logic   m_dir    = 1'b0;
  int     m_age    = SEQ_LEN;
  longint m_since  = 0;
  logic   m_dcmiss = 1'b0;

  function automatic int mag_of(input logic signed [16:0] pw);
    return (pw < 0) ? -int'(pw) : int'(pw);
  endfunction

  function automatic logic dce_exp();
`ifdef DCSTEP_EN
    return resetn && bus.enable_driver && bus.dc_enable;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge resetn) begin : model
    longint c;
    int     mag;
    if (!resetn) begin
      m_pos = 0; m_dir = 1'b0; m_age = SEQ_LEN; m_since = 0; m_dcmiss = 1'b0;
    end else if (bus.enable_driver) begin
      mag = mag_of(bus.pulsewidth);
      c   = (m_since >= 64'hFFFF_FFFF) ? m_since : m_since + 1;
      m_dcmiss = 1'b0;
      if (mag != 0 && c >= mag && m_age >= SEQ_LEN && !bus.pause) begin
        m_since = 0;
        m_dir   = (bus.pulsewidth < 0);
        m_age   = 0;
      end else begin
        m_since = c;
        if (m_age < SEQ_LEN) begin
          m_age++;
          if (m_age == 2) m_pos += m_dir ? -1 : 1;
          if (m_age == SEQ_LEN && dce_exp() && !bus.dco) m_dcmiss = 1'b1;
        end
      end
    end else begin
      m_dcmiss = 1'b0;
    end
  end

  logic running = 1'b1;

  always @(negedge clk) begin : compare
    logic exp_step;
    logic exp_dce;
    if (running) begin
      exp_step = (m_age >= 2) && (m_age < 2 + STEP_HIGH);
      exp_dce  = dce_exp();
      check("position", bus.position, m_pos);
      check("step",     bus.step,     exp_step);
      check("dir",      bus.dir,      m_dir);
      check("drv_enn",  bus.drv_enn,  !(resetn && bus.enable_driver));
      check("dce",      bus.dce,      exp_dce);
      check("dci",      bus.dci,      exp_step && exp_dce);
      check("dcmiss",   bus.dcmiss,   m_dcmiss);
    end
  end

  // Observed pulse statistics used by the literal checks.
  int   cyc = 0, rises = 0, last_rise = 0, last_period = 0;
  int   hi_cnt = 0, last_width = 0, miss_cnt = 0;
  logic prev_step = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.step && !prev_step) begin
      rises++;
      last_period = cyc - last_rise;
      last_rise   = cyc;
    end
    if (bus.step) hi_cnt++;
    else begin
      if (prev_step) last_width = hi_cnt;
      hi_cnt = 0;
    end
    prev_step = bus.step;
    if (bus.dcmiss) miss_cnt++;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_step(input logic lvl, input int budget);
    int k = 0;
    while (bus.step !== lvl && k < budget) begin
      cyc_wait(1);
      k++;
    end
    if (bus.step !== lvl) check("wait_step_timeout", bus.step, lvl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  logic [31:0] p;
  int          r0, m0;

  initial begin
    bus.pause = 1'b0; bus.enable_driver = 1'b0; bus.dc_enable = 1'b0;
    bus.pulsewidth = 17'sd0; bus.dco = 1'b0;
    cyc_wait(3);
    check("lit_reset_position", bus.position, 32'd0);
    check("lit_reset_step",     bus.step,     32'd0);
    check("lit_reset_drv_enn",  bus.drv_enn,  32'd1);

    // +100: triggers at edges 100/200/300, rises 2 cycles later.
    resetn = 1'b1; bus.enable_driver = 1'b1; bus.pulsewidth = 17'sd100;
    cyc_wait(330);
    check("lit_pos_after_3", bus.position, 32'd3);
    check("lit_dir_pos",     bus.dir,      32'd0);
    check("lit_rises_3",     rises,        32'd3);
    check("lit_period_100",  last_period,  32'd100);
    check("lit_width",       last_width,   STEP_HIGH);

    // -5: period limited to SEQ_LEN+1 = 23; four steps in 92 cycles.
    bus.pulsewidth = -17'sd5;
    cyc_wait(92);
    check("lit_pos_neg",     bus.position, 32'hFFFF_FFFF);
    check("lit_dir_neg",     bus.dir,      32'd1);
    check("lit_period_23",   last_period,  32'd23);

    // Sign flip just after a trigger: latched dir still decrements.
    cyc_wait(1);
    bus.pulsewidth = 17'sd100;
    cyc_wait(5);
    check("lit_flip_pos",    bus.position, 32'hFFFF_FFFE);
    check("lit_flip_dir",    bus.dir,      32'd1);
    bus.pulsewidth = -17'sd5;

    // Pause while STEP is high: pulse completes, nothing more until release.
    wait_step(1'b1, 40);
    bus.pause = 1'b1;
    p = bus.position; r0 = rises;
    cyc_wait(100);
    check("lit_pause_step",  bus.step,     32'd0);
    check("lit_pause_pos",   bus.position, p);
    check("lit_pause_rises", rises,        r0);
    bus.pause = 1'b0;
    cyc_wait(5);
    check("lit_resume_pos",  bus.position, p - 32'd1);

    // Disable with STEP high: everything freezes, ENN deasserts the driver.
    wait_step(1'b0, 40);
    wait_step(1'b1, 40);
    bus.enable_driver = 1'b0;
    p = bus.position;
    cyc_wait(50);
    check("lit_dis_enn",     bus.drv_enn,  32'd1);
    check("lit_dis_step",    bus.step,     32'd1);
    check("lit_dis_pos",     bus.position, p);
    bus.enable_driver = 1'b1;
    cyc_wait(40);

    // Asynchronous reset in the middle of a pulse.
    wait_step(1'b1, 40);
    resetn = 1'b0;
    #1;
    check("lit_areset_step", bus.step,     32'd0);
    check("lit_areset_pos",  bus.position, 32'd0);
    check("lit_areset_enn",  bus.drv_enn,  32'd1);
    bus.pulsewidth = 17'sd0;
    cyc_wait(3);
    resetn = 1'b1;
    r0 = rises;
    cyc_wait(50);
    check("lit_idle_pos",    bus.position, 32'd0);
    check("lit_idle_rises",  rises,        r0);

    // +1: triggers on the first enabled edge.
    bus.pulsewidth = 17'sd1;
    cyc_wait(3);
    check("lit_pw1_pos",     bus.position, 32'd1);
    cyc_wait(60);

`ifdef DCSTEP_EN
    bus.dc_enable = 1'b1; bus.dco = 1'b0;
    wait_step(1'b0, 40);
    m0 = miss_cnt; r0 = rises;
    cyc_wait(92);
    check("lit_dc_misses",   (miss_cnt - m0) >= 3, 32'd1);
    bus.dco = 1'b1;
    m0 = miss_cnt;
    cyc_wait(92);
    check("lit_dc_no_miss",  miss_cnt - m0, 32'd0);
`else
    m0 = miss_cnt;
    cyc_wait(46);
    check("lit_no_dcmiss",   miss_cnt - m0, 32'd0);
`endif

    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modport_stepgen.md
Name: modport_stepgen

Overview:
- Step/direction pulse generator driving a TMC5130A-class stepper driver from a signed step-period command.
- Sits between the motion-control register block (period, pause and enable inputs; position readback) and the driver pins (STEP, DIR, ENN, DCEN, DCIN, DCO).
- Tracks absolute step position as a signed 32-bit counter.

Parameters:
- CLK_FREQ, 100000000, clock frequency in Hz. Informational only; no timing depends on it.
- STEP_HIGH, 10, STEP high time in clk cycles (1..15).
- SEQ_LEN, 22, total step sequence length in cycles; must be at least STEP_HIGH+2.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- pause  in  1  1 = start no new steps.
- enable_driver  in  1  1 = driver and generator enabled.
- dc_enable  in  1  dcStep request; used only with DCSTEP_EN.
- pulsewidth  in  17  signed step period in clk cycles. Sign selects direction; 0 = stop.
- position  out  32  signed absolute step count.
- dcmiss  out  1  dcStep miss pulse.
- step  out  1  STEP pin.
- dir  out  1  DIR pin; 1 = negative direction.
- drv_enn  out  1  driver ENN, active-low.
- dce  out  1  DCEN pin.
- dci  out  1  DCIN pin.
- dco  in  1  DCO pin from driver.

Behaviour:
- Reset is asynchronous on resetn low: position=0, step=0, dir=0, period counter=0, sequence counter=0, dcmiss=0.
- drv_enn is combinational: !(resetn && enable_driver).
- Magnitude: mag = |pulsewidth|, computed in 17-bit unsigned; -65536 gives 65536.
- enable_driver=0: period counter and sequence counter freeze; step, dir and position hold.
- Each enabled cycle, let c = cnt+1.
  - Trigger when mag!=0, c>=mag, seq==0 and pause==0.
  - On trigger: cnt<=0, dir<=(pulsewidth<0), seq<=SEQ_LEN.
  - Otherwise cnt<=c. cnt is 32-bit and saturates at all-ones.
- While seq>0, each enabled cycle seq decrements; let s = seq-1.
  - s==SEQ_LEN-2: step<=1; position +1 if dir==0, else -1 (32-bit wrap).
  - s==SEQ_LEN-2-STEP_HIGH: step<=0.
- Default timing: STEP rises 2 cycles after the trigger edge, stays high 10 cycles, and the sequence ends 22 cycles after trigger.
- Step rate: one step per max(mag, SEQ_LEN+1) cycles, roughly.
- pause, or pulsewidth changing to 0 or flipping sign, does not abort an in-flight sequence. dir stays latched until the next trigger.
- Without DCSTEP_EN: dce=0, dci=0, dcmiss=0 constantly.

Optional Feature:
- Macro: DCSTEP_EN.
- When defined:
  - dce = resetn && enable_driver && dc_enable.
  - dci = step && dce.
  - dcmiss pulses high for 1 cycle when a sequence ends (seq 1->0) with dce=1 and dco=0.
- When undefined: dce, dci and dcmiss are tied to 0, and dco is ignored.

Test Plan:
- Reset mid-sequence (resetn low while step=1) -> step=0, position=0 immediately (asynchronous); after release, idle until a trigger.
- enable_driver=1, pulsewidth=100 -> step rises 2 cycles after trigger, high exactly 10 cycles; period 100 cycles; position increments 1,2,3; dir=0.
- pulsewidth=-5 -> period limited to 23 cycles; dir=1; position decrements by 1 per pulse.
- pause=1 while a sequence is in flight -> the current pulse completes; no further steps; position stable. Release pause -> stepping resumes.
- enable_driver=0 -> drv_enn=1; step, position and counters frozen. resetn=0 -> drv_enn=1.
- DCSTEP_EN, dc_enable=1, dco=0 -> dci mirrors step; one dcmiss pulse per step. With dco=1 -> dcmiss stays 0.
